// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipe_stage_buffer slice.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned PIPE_DATA_W = 160;
  localparam int unsigned PIPE_CTRL_W = 16;
  localparam int unsigned PIPE_CNT_W  = 16;

  // Maps a buffer state onto the number of entries it holds.
  function automatic logic [1:0] state_occupancy(input pipe_state_e st);
    logic [1:0] occ;
    case (st)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise step unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Two-entry skid buffer between pipeline stages (head + skid register).
// Define PIPE_STAGE_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W              = PIPE_DATA_W,
  parameter int unsigned CTRL_W              = PIPE_CTRL_W,
  parameter bit          CLEAR_DATA_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W               = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
`endif
  output logic [1:0]        occupancy
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q, in_ready_d;
  logic              push_s;
  logic              pop_s;

  assign push_s = in_valid & in_ready_q;
  assign pop_s  = (state_q != EMPTY) & out_ready;

  // Next state and storage; the head ctrl is zeroed whenever the buffer drains so out_ctrl reads as a bubble.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    skid_data_d = skid_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = EMPTY;
      head_ctrl_d = {CTRL_W{1'b0}};
      skid_ctrl_d = {CTRL_W{1'b0}};
      if (CLEAR_DATA_ON_FLUSH) begin
        head_data_d = {DATA_W{1'b0}};
        skid_data_d = {DATA_W{1'b0}};
      end else begin
        head_data_d = head_data_q;
        skid_data_d = skid_data_q;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_s) begin
            state_d     = ONE;
            head_data_d = in_data;
            head_ctrl_d = in_ctrl;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            state_d     = ONE;
            head_data_d = in_data;
            head_ctrl_d = in_ctrl;
          end else if (push_s) begin
            state_d     = FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (pop_s) begin
            state_d     = EMPTY;
            head_ctrl_d = {CTRL_W{1'b0}};
          end else begin
            state_d = ONE;
          end
        end
        FULL: begin
          if (pop_s) begin
            state_d     = ONE;
            head_data_d = skid_data_q;
            head_ctrl_d = skid_ctrl_q;
            skid_ctrl_d = {CTRL_W{1'b0}};
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d     = EMPTY;
          head_ctrl_d = {CTRL_W{1'b0}};
          skid_ctrl_d = {CTRL_W{1'b0}};
        end
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  // State, storage and registered in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_data_q <= {DATA_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
      head_ctrl_q <= {CTRL_W{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      skid_data_q <= skid_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_data_q;
  assign out_ctrl  = head_ctrl_q;
  assign occupancy = state_occupancy(state_q);

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc_s;
  logic flush_inc_s;

  assign stall_inc_s = out_valid & ~out_ready;
  assign flush_inc_s = flush & (state_q != EMPTY);

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc_s),
    .clear (1'b0),
    .cnt   (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc_s),
    .clear (1'b0),
    .cnt   (flush_cnt)
  );
`else
`endif

endmodule

// File: doc/pipe_stage_buffer.md
PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 Parameter DATA_W, default 160, width of the datapath payload (PC, PC+4, operands, immediate, register addresses, funct).
REQ-002 Parameter CTRL_W, default 16, width of the control bundle that becomes a bubble on flush.
REQ-003 Parameter CLEAR_DATA_ON_FLUSH, default 1, zeroes payload storage on flush when 1.
REQ-004 Parameter CNT_W, default 16, width of the performance counters.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 flush  in  1  synchronous kill of all held entries.
REQ-009 in_valid  in  1  upstream entry valid.
REQ-010 in_ready  out  1  buffer can accept; registered.
REQ-011 in_data  in  DATA_W  upstream payload.
REQ-012 in_ctrl  in  CTRL_W  upstream control bundle.
REQ-013 out_valid  out  1  head entry valid.
REQ-014 out_ready  in  1  downstream accepts head.
REQ-015 out_data  out  DATA_W  head payload.
REQ-016 out_ctrl  out  CTRL_W  head control, all-zero whenever out_valid=0.
REQ-017 occupancy  out  2  entries held, 0..2.
REQ-018 stall_cnt, flush_cnt  out  CNT_W each  present only with PIPE_STAGE_PERF_EN.

Function
REQ-019 The block SHALL be a 2-entry skid buffer with states EMPTY, ONE, FULL; push = in_valid&in_ready, pop = out_valid&out_ready.
REQ-020 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE with new head; FULL+pop->ONE with skid entry promoted to head; no push in FULL.
REQ-021 Latency in->out SHALL be exactly 1 cycle when EMPTY; entry order SHALL be preserved.
REQ-022 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, with no combinational path from out_ready.
REQ-023 out_valid SHALL equal (state != EMPTY); out_data/out_ctrl SHALL come from the head register.
REQ-024 flush SHALL move the state to EMPTY next edge, zero all stored ctrl, zero stored data if CLEAR_DATA_ON_FLUSH=1, and take priority over a simultaneous push or pop (incoming entry dropped).
REQ-025 Head and output values SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-026 While rst_n=0: state EMPTY, out_valid=0, in_ready=1, occupancy=0, out_data=0, out_ctrl=0, counters=0.
REQ-027 Reset asserted mid-transfer SHALL discard all entries immediately, with no partial pop.

Configuration
REQ-028 Macro PIPE_STAGE_PERF_EN defined: stall_cnt increments each cycle out_valid=1 and out_ready=0; flush_cnt increments each flush with state != EMPTY; both saturate at all-ones.
REQ-029 Macro PIPE_STAGE_PERF_EN undefined: counter ports and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the state typedef (EMPTY/ONE/FULL) and the default DATA_W/CTRL_W/CNT_W constants.
REQ-031 Counters SHALL be built from one sub-module, pipe_sat_counter (CNT_W parameter, inc/clear inputs), instantiated twice.

Verification
REQ-032 Reset, then in_valid=1, data=0xA5, out_ready=1 -> out_valid=1 with out_data=0xA5 the next cycle; occupancy=1.
REQ-033 out_ready=0 with pushes of D1, D2 -> occupancy=2, in_ready=0; out_ready=1 -> D1 then D2 on consecutive cycles.
REQ-034 FULL, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0; pushed entry never appears.
REQ-035 Streaming 100 entries with out_ready toggling randomly -> in-order, loss-free output; stall_cnt equals the count of stalled cycles.
REQ-036 rst_n pulsed low while FULL -> out_valid=0 and in_ready=1 asynchronously; counters=0.
REQ-037 CNT_W=4 with 20 stall cycles -> stall_cnt holds at 15.
